// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
//
// Upstream feeder for the frame buffer write port. Collects a narrow pixel
// stream into DATA_WIDTH words (first pixel of a word in the LSBs). It drives
// the frame buffer's active-low write enable, one word per write, and enforces
// a fixed frame length of WORDS_PER_FRAME words. Malformed frames (short, long,
// or restarted by an early sof) raise a sticky error flag.
//
// Optional feature macro: PIX_PACK_PAD_EN
//   defined   : a short frame is padded out. The partial word is zero-filled
//               and emitted, then all-zero words follow until the frame holds
//               WORDS_PER_FRAME words. frame_done pulses as for a good frame.
//   undefined : a short frame drops its partial word and returns to waiting
//               for sof. No frame_done, and the FLUSH state is not built.
//
// Ports
//   clk          in   single clock
//   reset        in   asynchronous reset, active low
//   pix_valid_in in   pixel qualifier (active high)
//   sof_in       in   start of frame, qualified by pix_valid_in
//   eof_in       in   end of frame on the last pixel, qualified by pix_valid_in
//   pix_in       in   pixel data [PIX_WIDTH]
//   fb_rdy       in   frame buffer accepts a word this cycle (active high)
//   pix_rdy      out  pixel accepted when pix_valid_in && pix_rdy
//   wr_en_out    out  active-low write enable; data_out valid while low
//   data_out     out  packed word [DATA_WIDTH]
//   word_cnt     out  words transferred in the current frame [CNT_WIDTH]
//   frame_done   out  one-cycle pulse after the last word of a frame transfers
//   frame_err    out  sticky malformed-frame flag, cleared only by reset
// -----------------------------------------------------------------------------
module pixel_packer #(
    parameter int PIX_WIDTH       = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int PIX_PER_WORD    = DATA_WIDTH / PIX_WIDTH,
    parameter int WORDS_PER_FRAME = 500,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid_in,
    input  logic                  sof_in,
    input  logic                  eof_in,
    input  logic [PIX_WIDTH-1:0]  pix_in,
    input  logic                  fb_rdy,
    output logic                  pix_rdy,
    output logic                  wr_en_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(PIX_PER_WORD - 1);
    localparam logic [CNT_WIDTH-1:0] FRAME_WORDS = CNT_WIDTH'(WORDS_PER_FRAME);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT    = CNT_WIDTH'(WORDS_PER_FRAME - 1);

`ifdef PIX_PACK_PAD_EN
    typedef enum logic [1:0] {
        WAIT_SOF,
        PACK,
        FLUSH
    } state_t;
`else
    typedef enum logic [0:0] {
        WAIT_SOF,
        PACK
    } state_t;
`endif

    state_t                  state, state_n;
    logic [LANE_W-1:0]       lane, lane_n;
    logic [DATA_WIDTH-1:0]   pack_buf, buf_n;
    logic [CNT_WIDTH-1:0]    words_made, made_n;
    logic                    out_valid;

    logic                    hold_free;
    logic                    transfer;
    logic                    accept;
    logic                    restart;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    err_set;

    logic [LANE_W-1:0]       eff_lane;
    logic [DATA_WIDTH-1:0]   eff_buf;
    logic [CNT_WIDTH-1:0]    eff_made;
    logic [DATA_WIDTH-1:0]   merged;
    logic [CNT_WIDTH-1:0]    made_inc;
    logic [CNT_WIDTH-1:0]    flush_inc;

    assign wr_en_out = !out_valid;

    // The holding register can take a new word when it is empty or its word
    // leaves this cycle. Only the pixel that would complete a word has to wait
    // for that; pixels filling lower lanes are always taken.
    always_comb begin
        hold_free = !out_valid || fb_rdy;
        transfer  = out_valid && fb_rdy;
        pix_rdy   = hold_free || (lane != LAST_LANE);
`ifdef PIX_PACK_PAD_EN
        if (state == FLUSH) begin
            pix_rdy = 1'b0;
        end
`endif
        accept  = pix_valid_in && pix_rdy;
        restart = accept && sof_in;
    end

    // Next-state and packing logic. An accepted sof always starts a fresh
    // frame, so the packing below works on "effective" lane/buffer/word count
    // values that are zeroed on a restart; a 1-pixel sof+eof frame then falls
    // out naturally as a short frame.
    always_comb begin
        state_n   = state;
        lane_n    = lane;
        buf_n     = pack_buf;
        made_n    = words_made;
        load      = 1'b0;
        load_data = pack_buf;
        err_set   = 1'b0;

        eff_lane  = restart ? '0 : lane;
        eff_buf   = restart ? '0 : pack_buf;
        eff_made  = restart ? '0 : words_made;
        merged    = eff_buf;
        merged[int'(eff_lane) * PIX_WIDTH +: PIX_WIDTH] = pix_in;
        made_inc  = eff_made + CNT_WIDTH'(1);
        flush_inc = words_made + CNT_WIDTH'(1);

        if (restart && (state == PACK)) begin
            err_set = 1'b1;
        end

        if (accept && (sof_in || (state == PACK))) begin
            state_n = PACK;
            if (eff_lane == LAST_LANE) begin
                load      = 1'b1;
                load_data = merged;
                lane_n    = '0;
                buf_n     = '0;
                made_n    = made_inc;
                if (made_inc == FRAME_WORDS) begin
                    // Frame is full; a missing eof means the source overran.
                    state_n = WAIT_SOF;
                    if (!eof_in) begin
                        err_set = 1'b1;
                    end
                end else if (eof_in) begin
                    err_set = 1'b1;
`ifdef PIX_PACK_PAD_EN
                    state_n = FLUSH;
`else
                    state_n = WAIT_SOF;
`endif
                end
            end else if (eof_in) begin
                err_set = 1'b1;
                lane_n  = '0;
                made_n  = eff_made;
`ifdef PIX_PACK_PAD_EN
                // Upper lanes of merged are already zero, so it is the
                // zero-filled partial word FLUSH sends first.
                buf_n   = merged;
                state_n = FLUSH;
`else
                buf_n   = '0;
                state_n = WAIT_SOF;
`endif
            end else begin
                lane_n = eff_lane + LANE_W'(1);
                buf_n  = merged;
                made_n = eff_made;
            end
        end

`ifdef PIX_PACK_PAD_EN
        // After the first (possibly partial) pad word pack_buf is zero, so
        // the remaining words are all-zero fill.
        if ((state == FLUSH) && hold_free) begin
            load      = 1'b1;
            load_data = pack_buf;
            buf_n     = '0;
            made_n    = flush_inc;
            if (flush_inc == FRAME_WORDS) begin
                state_n = WAIT_SOF;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers. A newly loaded word takes precedence over clearing
    // out_valid, which gives back-to-back words when fb_rdy stays high. An
    // accepted sof zeroes word_cnt even if a word transfers in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane       <= '0;
            pack_buf   <= '0;
            words_made <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            lane       <= lane_n;
            pack_buf   <= buf_n;
            words_made <= made_n;
            if (load) begin
                out_valid <= 1'b1;
                data_out  <= load_data;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
            if (restart) begin
                word_cnt <= '0;
            end else if (transfer) begin
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
            frame_done <= transfer && (word_cnt == LAST_CNT);
            if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_packer
//
// Self-checking bench for pixel_packer with PIX_WIDTH=8, DATA_WIDTH=32,
// WORDS_PER_FRAME=4. A frame-level reference model (pixel queue, word count,
// single-word output hold) is stepped once per cycle alongside the DUT and
// every output is compared against it. Directed frames pin the model with
// hand-computed words, followed by randomized frames and back-pressure.
// Honours PIX_PACK_PAD_EN for the short-frame expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pixel_packer;

    localparam int PW  = 8;
    localparam int DW  = 32;
    localparam int PPW = 4;
    localparam int WPF = 4;
    localparam int CW  = 16;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_PAD   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid_in;
    logic          sof_in;
    logic          eof_in;
    logic [PW-1:0] pix_in;
    logic          fb_rdy;
    logic          pix_rdy;
    logic          wr_en_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] word_cnt;
    logic          frame_done;
    logic          frame_err;

    always #5 clk = ~clk;

    pixel_packer #(
        .PIX_WIDTH       (PW),
        .DATA_WIDTH      (DW),
        .WORDS_PER_FRAME (WPF),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid_in (pix_valid_in),
        .sof_in       (sof_in),
        .eof_in       (eof_in),
        .pix_in       (pix_in),
        .fb_rdy       (fb_rdy),
        .pix_rdy      (pix_rdy),
        .wr_en_out    (wr_en_out),
        .data_out     (data_out),
        .word_cnt     (word_cnt),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    typedef struct packed {
        logic [PW-1:0] pix;
        logic          sof;
        logic          eof;
    } beat_t;

    beat_t         stream[$];

    // Reference model state
    int            mMode;
    logic [PW-1:0] mPix[$];
    int            mMade;
    bit            mHoldValid;
    logic [DW-1:0] mHoldData;
    int            mCnt;
    bit            mDone;
    bit            mErr;

    // Per-test observation logs
    logic [DW-1:0] mLog[$];
    logic [DW-1:0] dLog[$];
    logic [DW-1:0] expWords[$];
    int            dDone;
    int            mDoneN;
    int            dAccepted;
    int            lastStallAccepted;

    // Stimulus controls
    bit            fbRandom;
    bit            fbLow;
    bit            randPv;
    bit            stallArmed;
    int            stallLeft;

    int            nVectors;
    int            nMiscompares;

    task automatic compare(input string name, input logic [63:0] got, input logic [63:0] want);
        nVectors++;
        if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
        end
    endtask

    function automatic logic [DW-1:0] packPending();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < mPix.size(); k++) begin
            w = w | (DW'(mPix[k]) << (k * PW));
        end
        return w;
    endfunction

    function automatic bit modelRdy();
        return (mMode != M_PAD) &&
               (!mHoldValid || (fb_rdy == 1'b1) || (mPix.size() != PPW - 1));
    endfunction

    task automatic modelReset();
        mMode      = M_IDLE;
        mPix.delete();
        mMade      = 0;
        mHoldValid = 1'b0;
        mHoldData  = '0;
        mCnt       = 0;
        mDone      = 1'b0;
        mErr       = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit            rdy;
        bit            free;
        bit            xfer;
        bit            acc;
        bit            produced;
        logic [DW-1:0] word;
        rdy      = modelRdy();
        free     = !mHoldValid || (fb_rdy == 1'b1);
        xfer     = mHoldValid && (fb_rdy == 1'b1);
        acc      = (pix_valid_in == 1'b1) && rdy;
        produced = 1'b0;
        word     = '0;
        mDone    = xfer && (mCnt == WPF - 1);
        if (xfer) begin
            mLog.push_back(mHoldData);
            mHoldValid = 1'b0;
            mCnt++;
        end
        if ((mMode == M_PAD) && free) begin
            word = packPending();
            mPix.delete();
            produced = 1'b1;
            mMade++;
            if (mMade == WPF) mMode = M_IDLE;
        end
        if (acc) begin
            if (sof_in) begin
                if (mMode == M_FRAME) mErr = 1'b1;
                mPix.delete();
                mMade = 0;
                mCnt  = 0;
                mMode = M_FRAME;
            end
            if (mMode == M_FRAME) begin
                mPix.push_back(pix_in);
                if (mPix.size() == PPW) begin
                    word = packPending();
                    mPix.delete();
                    produced = 1'b1;
                    mMade++;
                    if (mMade == WPF) begin
                        mMode = M_IDLE;
                        if (!eof_in) mErr = 1'b1;
                    end else if (eof_in) begin
                        mErr = 1'b1;
`ifdef PIX_PACK_PAD_EN
                        mMode = M_PAD;
`else
                        mMode = M_IDLE;
`endif
                    end
                end else if (eof_in) begin
                    mErr = 1'b1;
`ifdef PIX_PACK_PAD_EN
                    mMode = M_PAD;
`else
                    mPix.delete();
                    mMode = M_IDLE;
`endif
                end
            end
        end
        if (produced) begin
            mHoldValid = 1'b1;
            mHoldData  = word;
        end
    endtask

    task automatic applyStimulus();
        if (stallArmed && mHoldValid) begin
            stallArmed = 1'b0;
            stallLeft  = 5;
        end
        if (fbLow) begin
            fb_rdy = 1'b0;
        end else if (stallLeft > 0) begin
            fb_rdy = 1'b0;
            stallLeft--;
        end else if (fbRandom) begin
            fb_rdy = ($urandom_range(0, 9) < 7);
        end else begin
            fb_rdy = 1'b1;
        end
        if ((stream.size() > 0) && (!randPv || ($urandom_range(0, 3) != 0))) begin
            pix_valid_in = 1'b1;
            pix_in       = stream[0].pix;
            sof_in       = stream[0].sof;
            eof_in       = stream[0].eof;
        end else begin
            pix_valid_in = 1'b0;
            pix_in       = PW'($urandom);
            sof_in       = 1'b0;
            eof_in       = 1'b0;
        end
    endtask

    task automatic checkOutput();
        compare("wr_en_out", 64'(wr_en_out), 64'(!mHoldValid));
        if (mHoldValid) compare("data_out", 64'(data_out), 64'(mHoldData));
        compare("word_cnt", 64'(word_cnt), 64'(mCnt));
        compare("frame_done", 64'(frame_done), 64'(mDone));
        compare("frame_err", 64'(frame_err), 64'(mErr));
        compare("pix_rdy", 64'(pix_rdy), 64'(modelRdy()));
        if ((wr_en_out == 1'b0) && (fb_rdy == 1'b1)) dLog.push_back(data_out);
        if ((pix_valid_in == 1'b1) && (pix_rdy == 1'b1)) dAccepted++;
        if (fb_rdy == 1'b0) lastStallAccepted = dAccepted;
        if (frame_done == 1'b1) dDone++;
        if (mDone) mDoneN++;
    endtask

    task automatic runCycle();
        bit acc;
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput();
        acc = (pix_valid_in == 1'b1) && modelRdy();
        modelStep();
        if (acc) void'(stream.pop_front());
    endtask

    task automatic runStream(input int budget, input int tail);
        int n;
        n = 0;
        while ((stream.size() > 0) && (n < budget)) begin
            runCycle();
            n++;
        end
        if (stream.size() > 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL stream_timeout: %0d beats left after %0d cycles", stream.size(), budget);
            stream.delete();
        end
        repeat (tail) runCycle();
    endtask

    // Assert reset asynchronously mid-cycle and check the outputs clear at once.
    task automatic resetDut();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        compare("rst_wr_en_out", 64'(wr_en_out), 64'd1);
        compare("rst_data_out", 64'(data_out), 64'd0);
        compare("rst_word_cnt", 64'(word_cnt), 64'd0);
        compare("rst_frame_done", 64'(frame_done), 64'd0);
        compare("rst_frame_err", 64'(frame_err), 64'd0);
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        eof_in       = 1'b0;
        fb_rdy       = 1'b1;
        modelReset();
        stream.delete();
        stallLeft  = 0;
        stallArmed = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clearLogs();
        mLog.delete();
        dLog.delete();
        dDone             = 0;
        mDoneN            = 0;
        dAccepted         = 0;
        lastStallAccepted = 0;
    endtask

    task automatic pushSeq(input int first, input int count, input bit sofFirst, input bit eofLast);
        beat_t b;
        for (int i = 0; i < count; i++) begin
            b.pix = PW'(first + i);
            b.sof = sofFirst && (i == 0);
            b.eof = eofLast && (i == count - 1);
            stream.push_back(b);
        end
    endtask

    task automatic pushRandom(input int count, input bit sofFirst, input bit eofLast);
        beat_t b;
        for (int i = 0; i < count; i++) begin
            b.pix = PW'($urandom);
            b.sof = sofFirst && (i == 0);
            b.eof = eofLast && (i == count - 1);
            stream.push_back(b);
        end
    endtask

    task automatic checkLogs(input string name);
        compare($sformatf("%s_nwords_model", name), 64'(mLog.size()), 64'(expWords.size()));
        compare($sformatf("%s_nwords_dut", name), 64'(dLog.size()), 64'(expWords.size()));
        for (int i = 0; i < expWords.size(); i++) begin
            compare($sformatf("%s_word%0d_model", name, i),
                    (i < mLog.size()) ? 64'(mLog[i]) : {64{1'bx}}, 64'(expWords[i]));
            compare($sformatf("%s_word%0d_dut", name, i),
                    (i < dLog.size()) ? 64'(dLog[i]) : {64{1'bx}}, 64'(expWords[i]));
        end
    endtask

    task automatic checkDone(input string name, input int want);
        compare($sformatf("%s_done_model", name), 64'(mDoneN), 64'(want));
        compare($sformatf("%s_done_dut", name), 64'(dDone), 64'(want));
    endtask

    task automatic randomTraffic(input int frames);
        int kind;
        for (int f = 0; f < frames; f++) begin
            if ($urandom_range(0, 39) == 0) resetDut();
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                pushRandom(PPW * WPF, 1'b1, 1'b1);
            end else if (kind <= 6) begin
                pushRandom($urandom_range(1, PPW * WPF - 1), 1'b1, 1'b1);
            end else if (kind == 7) begin
                pushRandom($urandom_range(PPW * WPF + 1, PPW * WPF + 8), 1'b1, 1'b0);
            end else if (kind == 8) begin
                pushRandom($urandom_range(1, PPW * WPF - 1), 1'b1, 1'b0);
                pushRandom(PPW * WPF, 1'b1, 1'b1);
            end else begin
                pushRandom($urandom_range(1, 5), 1'b0, 1'b0);
            end
            runStream(600, $urandom_range(0, 4));
        end
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        reset        = 1'b1;
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        eof_in       = 1'b0;
        pix_in       = '0;
        fb_rdy       = 1'b1;
        fbRandom     = 1'b0;
        fbLow        = 1'b0;
        randPv       = 1'b0;
        stallArmed   = 1'b0;
        stallLeft    = 0;
        modelReset();
        clearLogs();

        // Full frame, no back-pressure
        resetDut();
        clearLogs();
        pushSeq(1, 16, 1'b1, 1'b1);
        runStream(200, 6);
        expWords = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        checkLogs("full");
        checkDone("full", 1);
        compare("full_frame_err", 64'(frame_err), 64'd0);

        // Five stalled cycles after the first word appears
        resetDut();
        clearLogs();
        stallArmed = 1'b1;
        pushSeq(1, 16, 1'b1, 1'b1);
        runStream(200, 6);
        checkLogs("stall");
        checkDone("stall", 1);
        compare("stall_accepted", 64'(lastStallAccepted), 64'd7);

        // Short frame of six pixels
        resetDut();
        clearLogs();
        pushSeq(1, 6, 1'b1, 1'b1);
        runStream(200, 8);
`ifdef PIX_PACK_PAD_EN
        expWords = '{32'h04030201, 32'h00000605, 32'h00000000, 32'h00000000};
        checkLogs("short");
        checkDone("short", 1);
`else
        expWords = '{32'h04030201};
        checkLogs("short");
        checkDone("short", 0);
`endif
        compare("short_frame_err", 64'(frame_err), 64'd1);

        // sof re-asserted on pixel 6 (0xAA) restarts the frame
        resetDut();
        clearLogs();
        pushSeq(1, 5, 1'b1, 1'b0);
        stream.push_back('{pix: 8'hAA, sof: 1'b1, eof: 1'b0});
        pushSeq(7, 15, 1'b0, 1'b1);
        runStream(200, 6);
        expWords = '{32'h04030201, 32'h090807AA, 32'h0D0C0B0A, 32'h11100F0E, 32'h15141312};
        checkLogs("resof");
        checkDone("resof", 1);
        compare("resof_frame_err", 64'(frame_err), 64'd1);

        // Overlong frame, 20 pixels and no eof
        resetDut();
        clearLogs();
        pushSeq(1, 20, 1'b1, 1'b0);
        runStream(200, 6);
        expWords = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        checkLogs("long");
        checkDone("long", 1);
        compare("long_frame_err", 64'(frame_err), 64'd1);
        compare("long_wr_en_idle", 64'(wr_en_out), 64'd1);

        // Reset while a word is pending and the frame buffer is stalled
        resetDut();
        clearLogs();
        fbLow = 1'b1;
        pushSeq(1, 7, 1'b1, 1'b0);
        runStream(100, 3);
        compare("pend_wr_en_low", 64'(wr_en_out), 64'd0);
        fbLow = 1'b0;
        resetDut();
        clearLogs();
        pushSeq(1, 16, 1'b1, 1'b1);
        runStream(200, 6);
        expWords = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        checkLogs("after_rst");
        compare("after_rst_frame_err", 64'(frame_err), 64'd0);

        // Randomized frames, gaps and back-pressure
        resetDut();
        clearLogs();
        fbRandom = 1'b1;
        randPv   = 1'b1;
        randomTraffic(150);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
